// File: rtl/leaf_pkt_pkg.sv
// Shared field layout, credit limits, FSM states and the packet pack helper
// for the leaf transmit path.
package leaf_pkt_pkg;

  localparam int PACKET_BITS           = 49;
  localparam int PAYLOAD_BITS          = 32;
  localparam int NUM_LEAF_BITS         = 5;
  localparam int NUM_PORT_BITS         = 4;
  localparam int NUM_ADDR_BITS         = 7;
  localparam int FREESPACE_UPDATE_SIZE = 64;
  localparam int CREDIT_BITS           = 8;

  localparam int VALID_BIT = 48;
  localparam int LEAF_LSB  = 43;
  localparam int PORT_LSB  = 39;
  localparam int ADDR_LSB  = 32;

  localparam int MAX_CREDITS = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    STALL = 2'd2
  } state_e;

  function automatic logic [PACKET_BITS-1:0] pack_pkt(
    input logic [NUM_LEAF_BITS-1:0] leaf,
    input logic [NUM_PORT_BITS-1:0] port,
    input logic [NUM_ADDR_BITS-1:0] addr,
    input logic [PAYLOAD_BITS-1:0]  payload
  );
    logic [PACKET_BITS-1:0] p;
    p                                = '0;
    p[VALID_BIT]                     = 1'b1;
    p[LEAF_LSB +: NUM_LEAF_BITS]     = leaf;
    p[PORT_LSB +: NUM_PORT_BITS]     = port;
    p[ADDR_LSB +: NUM_ADDR_BITS]     = addr;
    p[PAYLOAD_BITS-1:0]              = payload;
    return p;
  endfunction

endpackage

// File: rtl/leaf_credit_counter.sv
// Receiver-buffer credit tracker: one credit per sent packet, a block of
// credits per return pulse, saturating at the buffer depth with a sticky flag.
module leaf_credit_counter
  import leaf_pkt_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   dec,
  input  logic                   inc,
  output logic [CREDIT_BITS-1:0] count,
  output logic                   overflow
);

  localparam int SW = CREDIT_BITS + 1;

  logic [CREDIT_BITS-1:0] count_q, count_d;
  logic                   overflow_q, overflow_d;
  logic [SW-1:0]          sum;

  always_comb begin
    sum = {1'b0, count_q}
        + (inc ? SW'(FREESPACE_UPDATE_SIZE) : SW'(0))
        - (dec ? SW'(1) : SW'(0));
    count_d    = sum[CREDIT_BITS-1:0];
    overflow_d = overflow_q;
    // dec is only issued with credits available, so sum never wraps below 0
    if (sum > SW'(MAX_CREDITS)) begin
      count_d    = CREDIT_BITS'(MAX_CREDITS);
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q    <= CREDIT_BITS'(MAX_CREDITS);
      overflow_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: rtl/leaf_stream_packetizer.sv
// Leaf transmit path: turns an ap_vld/ap_ack kernel stream into BFT packets,
// gated by receiver credits.
//   state | meaning
//   IDLE  | waiting for a kernel word; acks it when credits are available
//   SEND  | packet registered on dout with valid set, waiting for BFT ready
//   STALL | kernel word pending but no credits; waiting for a credit return
module leaf_stream_packetizer
  import leaf_pkt_pkg::*;
(
  input  logic                     clk_bft,
  input  logic                     reset_bft_n,
  input  logic [NUM_LEAF_BITS-1:0] dest_leaf,
  input  logic [NUM_PORT_BITS-1:0] dest_port,
  input  logic [PAYLOAD_BITS-1:0]  din_user2pkt,
  input  logic                     vld_user2pkt,
  output logic                     ack_pkt2user,
  output logic [PACKET_BITS-1:0]   dout_pkt2bft,
  input  logic                     ready_bft2pkt,
  input  logic                     credit_return,
  output logic [CREDIT_BITS-1:0]   credit_count,
  output logic                     credit_overflow
);

  state_e                   state_q, state_d;
  logic [NUM_ADDR_BITS-1:0] addr_q, addr_d;
  logic [PACKET_BITS-1:0]   pkt_q, pkt_d;
  logic                     send;

  leaf_credit_counter u_credit (
    .clk      (clk_bft),
    .rst_n    (reset_bft_n),
    .dec      (send),
    .inc      (credit_return),
    .count    (credit_count),
    .overflow (credit_overflow)
  );

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    pkt_d        = pkt_q;
    ack_pkt2user = 1'b0;
    case (state_q)
      IDLE: begin
        if (vld_user2pkt) begin
          if (credit_count != '0) begin
            ack_pkt2user = 1'b1;
            pkt_d        = pack_pkt(dest_leaf, dest_port, addr_q, din_user2pkt);
            addr_d       = addr_q + 1'b1;
            state_d      = SEND;
          end else begin
            state_d = STALL;
          end
        end
      end
      SEND: begin
        // dropping the whole packet keeps dout at zero outside SEND
        if (ready_bft2pkt) begin
          pkt_d   = '0;
          state_d = IDLE;
        end
      end
      STALL: begin
        if (credit_count != '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign send = ack_pkt2user;

  always_ff @(posedge clk_bft) begin
    if (!reset_bft_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      pkt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      pkt_q   <= pkt_d;
    end
  end

  assign dout_pkt2bft = pkt_q;

endmodule

// File: tb/tb_leaf_stream_packetizer.sv
// Scoreboard bench for leaf_stream_packetizer: packets expected at ack time are
// queued and compared when they leave on the BFT side.
module tb_leaf_stream_packetizer;
  import leaf_pkt_pkg::*;

  logic        clk_bft = 1'b0;
  logic        reset_bft_n = 1'b0;
  logic [4:0]  dest_leaf = '0;
  logic [3:0]  dest_port = '0;
  logic [31:0] din_user2pkt = '0;
  logic        vld_user2pkt = 1'b0;
  logic        ack_pkt2user;
  logic [48:0] dout_pkt2bft;
  logic        ready_bft2pkt = 1'b1;
  logic        credit_return = 1'b0;
  logic [7:0]  credit_count;
  logic        credit_overflow;

  leaf_stream_packetizer dut (
    .clk_bft         (clk_bft),
    .reset_bft_n     (reset_bft_n),
    .dest_leaf       (dest_leaf),
    .dest_port       (dest_port),
    .din_user2pkt    (din_user2pkt),
    .vld_user2pkt    (vld_user2pkt),
    .ack_pkt2user    (ack_pkt2user),
    .dout_pkt2bft    (dout_pkt2bft),
    .ready_bft2pkt   (ready_bft2pkt),
    .credit_return   (credit_return),
    .credit_count    (credit_count),
    .credit_overflow (credit_overflow)
  );

  always #5 clk_bft = ~clk_bft;

  int          n_cmp = 0;
  int          n_err = 0;
  int          n_deliv = 0;
  logic [6:0]  exp_addr = '0;
  logic [48:0] exp_pkt;
  logic [48:0] sb[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: push on ack, pop on delivered packet
  always @(negedge clk_bft) begin
    if (reset_bft_n) begin
      if (ack_pkt2user) begin
        sb.push_back({1'b1, dest_leaf, dest_port, exp_addr, din_user2pkt});
        exp_addr = exp_addr + 7'd1;
      end
      if (dout_pkt2bft[48] && ready_bft2pkt) begin
        chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          exp_pkt = sb.pop_front();
          chk("pkt", 64'(dout_pkt2bft), 64'(exp_pkt));
        end
        n_deliv++;
      end
    end
  end

  task automatic do_reset();
    @(posedge clk_bft); #1;
    reset_bft_n   = 1'b0;
    vld_user2pkt  = 1'b0;
    credit_return = 1'b0;
    repeat (2) @(posedge clk_bft);
    #1;
    sb.delete();
    exp_addr    = '0;
    reset_bft_n = 1'b1;
  endtask

  task automatic wait_ack(input int max_cyc, output bit got);
    got = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk_bft);
      if (ack_pkt2user) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  // called at posedge+1; returns at posedge+1 with vld dropped if acked, held otherwise
  task automatic put_word(input logic [31:0] d, input logic [4:0] l, input logic [3:0] p,
                          input int max_cyc, output bit got);
    din_user2pkt = d;
    dest_leaf    = l;
    dest_port    = p;
    vld_user2pkt = 1'b1;
    wait_ack(max_cyc, got);
    @(posedge clk_bft); #1;
    if (got) vld_user2pkt = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    int base;

    do_reset();
    @(negedge clk_bft);
    chk("rst_dout", 64'(dout_pkt2bft), 64'd0);
    chk("rst_ack", 64'(ack_pkt2user), 64'd0);
    chk("rst_credit", 64'(credit_count), 64'd128);
    chk("rst_ovf", 64'(credit_overflow), 64'd0);
    chk("rst_state", 64'(dut.state_q), 64'(IDLE));

    // first word: combinational ack, packet one cycle later
    @(posedge clk_bft); #1;
    din_user2pkt = 32'hDEADBEEF;
    dest_leaf    = 5'd3;
    dest_port    = 4'd2;
    vld_user2pkt = 1'b1;
    @(negedge clk_bft);
    chk("t1_ack", 64'(ack_pkt2user), 64'd1);
    chk("t1_credit_ack", 64'(credit_count), 64'd128);
    @(posedge clk_bft); #1;
    vld_user2pkt = 1'b0;
    @(negedge clk_bft);
    chk("t1_dout", 64'(dout_pkt2bft), 64'({1'b1, 5'd3, 4'd2, 7'd0, 32'hDEADBEEF}));
    chk("t1_credit", 64'(credit_count), 64'd127);
    chk("t1_ack_send", 64'(ack_pkt2user), 64'd0);

    // drain all credits with back-to-back words
    do_reset();
    base = n_deliv;
    for (int i = 0; i < 128; i++) begin
      put_word(32'h1000_0000 + 32'(i), 5'(i), 4'(i), 4, got);
      chk("t2_ack", 64'(got), 64'd1);
    end
    put_word(32'hC0DE_0129, 5'd9, 4'd1, 6, got);
    chk("t2_no_ack_129", 64'(got), 64'd0);
    @(negedge clk_bft);
    chk("t2_credit0", 64'(credit_count), 64'd0);
    chk("t2_stall", 64'(dut.state_q), 64'(STALL));
    chk("t2_delivered", 64'(n_deliv - base), 64'd128);

    // credit return releases the stalled word with wrapped address
    @(posedge clk_bft); #1;
    credit_return = 1'b1;
    @(posedge clk_bft); #1;
    credit_return = 1'b0;
    @(negedge clk_bft);
    chk("t3_credit64", 64'(credit_count), 64'd64);
    wait_ack(2, got);
    chk("t3_ack", 64'(got), 64'd1);
    @(posedge clk_bft); #1;
    vld_user2pkt = 1'b0;
    @(negedge clk_bft);
    chk("t3_credit63", 64'(credit_count), 64'd63);

    // BFT back-pressure holds the packet; next word waits
    @(posedge clk_bft); #1;
    ready_bft2pkt = 1'b0;
    base = n_deliv;
    put_word(32'hA5A5_0001, 5'd7, 4'd5, 4, got);
    chk("t4_ack_a", 64'(got), 64'd1);
    din_user2pkt = 32'h5A5A_0002;
    dest_leaf    = 5'd8;
    dest_port    = 4'd6;
    vld_user2pkt = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_bft);
      chk("t4_hold", 64'(dout_pkt2bft), 64'({1'b1, 5'd7, 4'd5, 7'd1, 32'hA5A5_0001}));
      chk("t4_no_ack", 64'(ack_pkt2user), 64'd0);
    end
    @(posedge clk_bft); #1;
    ready_bft2pkt = 1'b1;
    wait_ack(4, got);
    chk("t4_ack_b", 64'(got), 64'd1);
    @(posedge clk_bft); #1;
    vld_user2pkt = 1'b0;
    repeat (2) @(posedge clk_bft);
    #1;
    chk("t4_delivered", 64'(n_deliv - base), 64'd2);

    // send and credit return together at 100 credits saturates
    do_reset();
    for (int i = 0; i < 28; i++) begin
      put_word(32'hB000_0000 + 32'(i), 5'd1, 4'd1, 4, got);
    end
    @(negedge clk_bft);
    @(posedge clk_bft); #1;
    chk("t5_credit100", 64'(credit_count), 64'd100);
    din_user2pkt  = 32'hFACE_0100;
    vld_user2pkt  = 1'b1;
    credit_return = 1'b1;
    @(negedge clk_bft);
    chk("t5_ack", 64'(ack_pkt2user), 64'd1);
    @(posedge clk_bft); #1;
    vld_user2pkt  = 1'b0;
    credit_return = 1'b0;
    chk("t5_sat", 64'(credit_count), 64'd128);
    chk("t5_ovf", 64'(credit_overflow), 64'd1);
    @(negedge clk_bft);
    @(posedge clk_bft); #1;
    for (int i = 0; i < 3; i++) begin
      put_word(32'hE000_0000 + 32'(i), 5'd2, 4'd3, 4, got);
    end
    chk("t5_credit125", 64'(credit_count), 64'd125);
    chk("t5_ovf_sticky", 64'(credit_overflow), 64'd1);

    // reset while a packet is waiting in SEND drops it
    @(negedge clk_bft);
    @(posedge clk_bft); #1;
    ready_bft2pkt = 1'b0;
    put_word(32'h0BAD_F00D, 5'd4, 4'd4, 4, got);
    chk("t6_valid", 64'(dout_pkt2bft[48]), 64'd1);
    reset_bft_n = 1'b0;
    @(posedge clk_bft); #1;
    chk("t6_dout", 64'(dout_pkt2bft), 64'd0);
    chk("t6_credit", 64'(credit_count), 64'd128);
    chk("t6_ovf", 64'(credit_overflow), 64'd0);
    chk("t6_addr", 64'(dut.addr_q), 64'd0);
    chk("t6_state", 64'(dut.state_q), 64'(IDLE));
    sb.delete();
    exp_addr      = '0;
    reset_bft_n   = 1'b1;
    ready_bft2pkt = 1'b1;
    put_word(32'h1234_5678, 5'd31, 4'd15, 4, got);
    chk("t6_post_ack", 64'(got), 64'd1);
    repeat (3) @(posedge clk_bft);
    #1;
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
